// File: rtl/alu_exec_if.sv
// Handshake bundle between the ALU control decoder, the execute stage and writeback.
interface alu_exec_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAGW  = 3
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_code;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [TAGW-1:0]  out_tag;
    logic             zero;
    logic             carry;
    logic             ovf;

    modport slave (
        input  in_valid, alu_code, op_a, op_b, in_tag, out_ready,
        output in_ready, out_valid, result, out_tag, zero, carry, ovf
    );

    modport master (
        output in_valid, alu_code, op_a, op_b, in_tag, out_ready,
        input  in_ready, out_valid, result, out_tag, zero, carry, ovf
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: single-cycle ops plus an iterative one-bit-per-cycle LSL,
// with valid/ready on both sides and a held result for writeback/branch resolution.
module alu_exec_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAGW  = 3,
    parameter int unsigned SHW   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    alu_exec_if.slave  io
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_LSL = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [TAGW-1:0]  tag_q, tag_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic             in_ready_c;
    logic             accept_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             alu_carry_c;
    logic             alu_ovf_c;
    logic [SHW-1:0]   shamt_c;
    logic [WIDTH-1:0] acc_shl_c;

    assign in_ready_c = ~flush & ((state_q == IDLE) | ((state_q == HOLD) & io.out_ready));
    assign accept_c   = io.in_valid & in_ready_c;
    assign shamt_c    = io.op_b[SHW-1:0];
    assign acc_shl_c  = {acc_q[WIDTH-2:0], 1'b0};

    // Single-cycle datapath; carry is the raw carry for add and the borrow for sub.
    always_comb begin
        sum_c       = {1'b0, io.op_a} + {1'b0, io.op_b};
        diff_c      = {1'b0, io.op_a} - {1'b0, io.op_b};
        alu_res_c   = '0;
        alu_carry_c = 1'b0;
        alu_ovf_c   = 1'b0;
        unique case (io.alu_code)
            OP_ADD: begin
                alu_res_c   = sum_c[WIDTH-1:0];
                alu_carry_c = sum_c[WIDTH];
                alu_ovf_c   = (io.op_a[WIDTH-1] == io.op_b[WIDTH-1]) &
                              (sum_c[WIDTH-1] != io.op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_c   = diff_c[WIDTH-1:0];
                alu_carry_c = diff_c[WIDTH];
                alu_ovf_c   = (io.op_a[WIDTH-1] != io.op_b[WIDTH-1]) &
                              (diff_c[WIDTH-1] != io.op_a[WIDTH-1]);
            end
            OP_SLT: alu_res_c = WIDTH'($signed(io.op_a) < $signed(io.op_b));
            OP_AND: alu_res_c = io.op_a & io.op_b;
            OP_OR:  alu_res_c = io.op_a | io.op_b;
            OP_NOT: alu_res_c = ~io.op_a;
            OP_XOR: alu_res_c = io.op_a ^ io.op_b;
            default: alu_res_c = io.op_a;
        endcase
    end

    // Next-state logic; an accept in HOLD retires the held result and starts the new op.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        tag_d    = tag_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, HOLD: begin
                    if (accept_c) begin
                        tag_d = io.in_tag;
                        if (io.alu_code == OP_LSL) begin
                            acc_d = io.op_a;
                            cnt_d = shamt_c;
                            if (shamt_c == '0) begin
                                state_d  = HOLD;
                                result_d = io.op_a;
                                zero_d   = (io.op_a == '0);
                                carry_d  = 1'b0;
                                ovf_d    = 1'b0;
                            end else begin
                                state_d = BUSY;
                            end
                        end else begin
                            state_d  = HOLD;
                            result_d = alu_res_c;
                            zero_d   = (alu_res_c == '0);
                            carry_d  = alu_carry_c;
                            ovf_d    = alu_ovf_c;
                        end
                    end else if (state_q == HOLD && io.out_ready) begin
                        state_d = IDLE;
                    end
                end
                BUSY: begin
                    acc_d = acc_shl_c;
                    cnt_d = cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_d  = HOLD;
                        result_d = acc_shl_c;
                        zero_d   = (acc_shl_c == '0);
                        carry_d  = 1'b0;
                        ovf_d    = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            tag_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign io.in_ready  = in_ready_c;
    assign io.out_valid = (state_q == HOLD);
    assign io.result    = result_q;
    assign io.out_tag   = tag_q;
    assign io.zero      = zero_q;
    assign io.carry     = carry_q;
    assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: expected results queued at accept, compared at output transfer.
module tb_alu_exec_stage;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    alu_exec_if #(.WIDTH(16), .TAGW(3)) io ();

    alu_exec_stage #(.WIDTH(16), .TAGW(3), .SHW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .io    (io.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  tag;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input logic [2:0] code, input logic [15:0] a, input logic [15:0] b,
                                   input logic [2:0] tag);
        exp_t e;
        int   sa = $signed(a);
        int   sbv = $signed(b);
        int   s;
        logic [16:0] w;
        e = '0;
        e.tag = tag;
        case (code)
            3'b000: begin
                w = {1'b0, a} + {1'b0, b};
                e.res = w[15:0];
                e.c = w[16];
                s = sa + sbv;
                e.v = (s > 32767) || (s < -32768);
            end
            3'b001: begin
                e.res = a - b;
                e.c = (a < b);
                s = sa - sbv;
                e.v = (s > 32767) || (s < -32768);
            end
            3'b010: e.res = a << b[3:0];
            3'b011: e.res = (sa < sbv) ? 16'd1 : 16'd0;
            3'b100: e.res = a & b;
            3'b101: e.res = a | b;
            3'b110: e.res = ~a;
            default: e.res = a ^ b;
        endcase
        e.z = (e.res == 16'h0000);
        return e;
    endfunction

    // Output monitor: a transfer happens at the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (rst === 1'b0 && io.out_valid === 1'b1 && io.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(io.out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 32'(io.result), 32'(e.res));
                chk("out_tag", 32'(io.out_tag), 32'(e.tag));
                chk("zero", 32'(io.zero), 32'(e.z));
                chk("carry", 32'(io.carry), 32'(e.c));
                chk("ovf", 32'(io.ovf), 32'(e.v));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] code, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] tag, input bit push);
        int n = 0;
        io.in_valid = 1'b1;
        io.alu_code = code;
        io.op_a     = a;
        io.op_b     = b;
        io.in_tag   = tag;
        #0;
        while (io.in_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("accept_ready", 32'(io.in_ready), 32'd1);
        if (push) sb.push_back(model(code, a, b, tag));
        step();
        io.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        rst = 1'b1;
        flush = 1'b0;
        io.in_valid = 1'b0;
        io.alu_code = 3'b000;
        io.op_a = '0;
        io.op_b = '0;
        io.in_tag = '0;
        io.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(io.out_valid), 32'd0);
        chk("rst_result", 32'(io.result), 32'd0);
        chk("rst_in_ready", 32'(io.in_ready), 32'd1);

        // add with signed overflow, latency 1
        io.out_ready = 1'b1;
        send(3'b000, 16'h7FFF, 16'h0001, 3'd5, 1);
        chk("add_latency", 32'(io.out_valid), 32'd1);
        step();

        // back-to-back subs: equal, then borrow
        send(3'b001, 16'h0005, 16'h0005, 3'd1, 1);
        send(3'b001, 16'h0003, 16'h0005, 3'd2, 1);
        chk("sub2_valid", 32'(io.out_valid), 32'd1);
        step();

        // unsigned wrap
        send(3'b000, 16'hFFFF, 16'h0001, 3'd4, 1);
        step();

        // lsl 3<<4: in_ready low for 4 cycles, out_valid in cycle 5
        send(3'b010, 16'h0003, 16'h0004, 3'd3, 1);
        cyc = 1;
        while (io.out_valid !== 1'b1 && cyc < 50) begin
            chk("lsl_busy_in_ready", 32'(io.in_ready), 32'd0);
            step();
            cyc++;
        end
        chk("lsl_latency", 32'(cyc), 32'd5);
        step();

        // lsl by 0 completes in one cycle
        send(3'b010, 16'h0003, 16'h0000, 3'd6, 1);
        chk("lsl0_latency", 32'(io.out_valid), 32'd1);
        step();

        // not ignores op_b
        send(3'b110, 16'h00FF, 16'h1234, 3'd0, 1);
        step();

        // back-pressure on a held xor
        io.out_ready = 1'b0;
        send(3'b111, 16'h00FF, 16'h0F0F, 3'd4, 1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(io.out_valid), 32'd1);
            chk("bp_result", 32'(io.result), 32'h0FF0);
            chk("bp_in_ready", 32'(io.in_ready), 32'd0);
            step();
        end
        io.out_ready = 1'b1;
        send(3'b011, 16'hFFFF, 16'h0001, 3'd6, 1);
        chk("b2b_no_gap", 32'(io.out_valid), 32'd1);
        chk("b2b_result", 32'(io.result), 32'd1);
        step();
        chk("drain_idle", 32'(io.out_valid), 32'd0);

        // flush on the 3rd BUSY cycle of lsl 1<<15
        send(3'b010, 16'h0001, 16'h000F, 3'd7, 0);
        chk("fl_busy1", 32'(io.out_valid), 32'd0);
        step();
        chk("fl_busy2", 32'(io.out_valid), 32'd0);
        step();
        flush = 1'b1;
        io.in_valid = 1'b1;
        io.alu_code = 3'b000;
        io.op_a = 16'h0001;
        io.op_b = 16'h0001;
        #1;
        chk("fl_in_ready", 32'(io.in_ready), 32'd0);
        step();
        flush = 1'b0;
        io.in_valid = 1'b0;
        #1;
        chk("fl_after_valid", 32'(io.out_valid), 32'd0);
        chk("fl_after_ready", 32'(io.in_ready), 32'd1);
        for (int i = 0; i < 18; i++) begin
            step();
            chk("fl_never_valid", 32'(io.out_valid), 32'd0);
        end
        send(3'b100, 16'hF0F0, 16'hFF00, 3'd2, 1);
        chk("and_valid", 32'(io.out_valid), 32'd1);
        chk("and_result", 32'(io.result), 32'hF000);
        step();

        // reset beats flush and a pending accept while holding
        io.out_ready = 1'b0;
        send(3'b101, 16'h1234, 16'h0001, 3'd2, 1);
        chk("hold_before_rst", 32'(io.out_valid), 32'd1);
        rst = 1'b1;
        flush = 1'b1;
        io.in_valid = 1'b1;
        io.alu_code = 3'b000;
        io.op_a = 16'h7FFF;
        io.op_b = 16'h7FFF;
        step();
        rst = 1'b0;
        flush = 1'b0;
        io.in_valid = 1'b0;
        sb.delete();
        #1;
        chk("rst2_out_valid", 32'(io.out_valid), 32'd0);
        chk("rst2_result", 32'(io.result), 32'd0);
        chk("rst2_out_tag", 32'(io.out_tag), 32'd0);
        chk("rst2_flags", 32'({io.zero, io.carry, io.ovf}), 32'd0);
        chk("rst2_in_ready", 32'(io.in_ready), 32'd1);

        io.out_ready = 1'b1;
        send(3'b110, 16'h00FF, 16'h0000, 3'd3, 1);
        step();
        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
